// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, requester indices, bus widths and the round-robin pick rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;  // instruction fetch port, read-only
  localparam logic M1 = 1'b1;  // data port, read/write

  localparam int ADDR_W = 30;
  localparam int DATA_W = 64;

  // Winner for a request pair: a lone requester wins outright, a tie goes
  // to whichever requester did not win the previous tie.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last);
    logic win;
    win = M0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = M1;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one requester at a time to a shared
// single-ported memory, waits for mem_ready (bounded by TIMEOUT cycles),
// then returns a one-cycle ack with read data or a timeout error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // Counter is wide enough to hold TIMEOUT itself, so it can never wrap.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last ACCESS cycle index before giving up (cycle count reaches TIMEOUT).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_reg;
  logic              grant_reg;
  logic              last_grant_reg;
  logic              wen_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic              grant_next;
  logic [1:0]        ack_vec;

  assign grant_next = pick_winner(m0_req, m1_req, last_grant_reg);

  // Arbitration FSM: latch the winning request, run the memory access, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= M0;
      last_grant_reg <= M1;
      wen_reg        <= 1'b0;
      err_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant_reg <= grant_next;
            // The round-robin pointer only moves when there was a contest.
            if (m0_req && m1_req) begin
              last_grant_reg <= grant_next;
            end
            wen_reg      <= (grant_next == M1) ? m1_wen : 1'b0;
            addr_reg     <= (grant_next == M1) ? m1_addr : m0_addr;
            wdata_reg    <= (grant_next == M1) ? m1_wdata : '0;
            wait_cnt_reg <= '0;
            state_reg    <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready wins over timeout when both land in the same cycle.
          if (mem_ready) begin
            rdata_reg <= wen_reg ? '0 : mem_rdata;
            err_reg   <= 1'b0;
            state_reg <= RESP;
          end else if (wait_cnt_reg == CNT_LAST) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Per-requester ack decode; only the granted port sees RESP.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign m0_ack   = ack_vec[0];
  assign m0_rdata = ack_vec[0] ? rdata_reg : '0;
  assign m0_err   = ack_vec[0] & err_reg;
  assign m1_ack   = ack_vec[1];
  assign m1_rdata = ack_vec[1] ? rdata_reg : '0;
  assign m1_err   = ack_vec[1] & err_reg;

  // Memory side is driven purely from latched values, quiet outside ACCESS.
  assign mem_cen   = (state_reg == ACCESS);
  assign mem_wen   = mem_cen & wen_reg;
  assign mem_addr  = mem_cen ? addr_reg : '0;
  assign mem_wdata = mem_cen ? wdata_reg : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of grant, latency and response.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req;
  logic [29:0] m0_addr;
  logic        m0_ack;
  logic [63:0] m0_rdata;
  logic        m0_err;
  logic        m1_req;
  logic        m1_wen;
  logic [29:0] m1_addr;
  logic [63:0] m1_wdata;
  logic        m1_ack;
  logic [63:0] m1_rdata;
  logic        m1_err;
  logic        mem_cen;
  logic        mem_wen;
  logic [29:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  int   checks = 0;
  int   failures = 0;
  logic pend0, pend1;   // requester has an outstanding request
  logic exp_last;       // model: winner of the previous tie

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int r);
    if (r == 0) begin
      pend0 = 1'b1; m0_req = 1'b1; m0_addr = 30'($urandom());
    end else begin
      pend1 = 1'b1; m1_req = 1'b1; m1_wen = 1'($urandom_range(0, 1));
      m1_addr = 30'($urandom()); m1_wdata = rand64();
    end
  endtask

  // One IDLE cycle, then (if anything is pending) a full transaction whose
  // memory answers in ACCESS cycle d (d >= TO means never).
  task automatic step_txn(input int d, input logic [63:0] rd, input bit keep, input bit wiggle);
    int          w, len;
    logic        exp_wen, exp_err;
    logic [29:0] exp_addr;
    logic [63:0] exp_wd, exp_rd;
    @(negedge clk);
    chk("idle_mem_cen", mem_cen, 0);
    chk("idle_mem_wen", mem_wen, 0);
    chk("idle_m0_ack", m0_ack, 0);
    chk("idle_m1_ack", m1_ack, 0);
    chk("idle_m0_rdata", m0_rdata, 0);
    chk("idle_m1_rdata", m1_rdata, 0);
    chk("idle_m0_err", m0_err, 0);
    chk("idle_m1_err", m1_err, 0);
    if (wiggle) begin
      if (!pend0 && $urandom_range(0, 1) == 1) raise(0);
      if (!pend1 && $urandom_range(0, 1) == 1) raise(1);
    end
    m0_req = pend0;
    m1_req = pend1;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = rand64();
    if (!pend0 && !pend1) return;
    if (pend0 && pend1) begin
      w = exp_last ? 0 : 1;
      exp_last = (w == 1);
    end else begin
      w = pend0 ? 0 : 1;
    end
    exp_wen  = (w == 1) ? m1_wen : 1'b0;
    exp_addr = (w == 1) ? m1_addr : m0_addr;
    exp_wd   = m1_wdata;
    len      = (d < TO) ? d + 1 : TO;
    exp_err  = (d >= TO);
    exp_rd   = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("acc_mem_cen", mem_cen, 1);
      chk("acc_mem_wen", mem_wen, exp_wen);
      chk("acc_mem_addr", mem_addr, exp_addr);
      if (exp_wen) chk("acc_mem_wdata", mem_wdata, exp_wd);
      chk("acc_m0_ack", m0_ack, 0);
      chk("acc_m1_ack", m1_ack, 0);
      mem_ready = (k == d);
      mem_rdata = (k == d) ? rd : rand64();
      if (k == d && !exp_wen) exp_rd = rd;
      if (wiggle) begin
        if (w == 1 && !pend0 && $urandom_range(0, 3) == 0) raise(0);
        if (w == 0 && !pend1 && $urandom_range(0, 3) == 0) raise(1);
      end
    end
    @(negedge clk);
    chk("resp_mem_cen", mem_cen, 0);
    chk("resp_m0_ack", m0_ack, (w == 0));
    chk("resp_m1_ack", m1_ack, (w == 1));
    chk("resp_m0_rdata", m0_rdata, (w == 0) ? exp_rd : 64'd0);
    chk("resp_m1_rdata", m1_rdata, (w == 1) ? exp_rd : 64'd0);
    chk("resp_m0_err", m0_err, (w == 0) ? exp_err : 1'b0);
    chk("resp_m1_err", m1_err, (w == 1) ? exp_err : 1'b0);
    $display("txn grant=M%0d d=%0d wen=%0d addr=%h err=%0d rdata=%h",
             w, d, exp_wen, exp_addr, exp_err, exp_rd);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = rand64();
    if (!keep) begin
      if (w == 0) begin pend0 = 1'b0; m0_req = 1'b0; end
      else begin pend1 = 1'b0; m1_req = 1'b0; end
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_addr = '0; m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    pend0 = 0; pend1 = 0; exp_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_cen", mem_cen, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_err", m1_err, 0);
    rst = 1'b0;

    // Single read from m0 answered in the first ACCESS cycle.
    pend0 = 1'b1; m0_addr = 30'h10;
    step_txn(0, 64'hDEAD_BEEF_0000_0001, 0, 0);

    // Both held: grants alternate M0, M1, M0, M1 every 3 cycles.
    pend0 = 1'b1; m0_addr = 30'h20;
    pend1 = 1'b1; m1_wen = 1'b0; m1_addr = 30'h21; m1_wdata = rand64();
    repeat (4) step_txn(0, rand64(), 1, 0);
    pend0 = 1'b0; pend1 = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

    // Write from m1, memory ready in the 4th ACCESS cycle.
    pend1 = 1'b1; m1_wen = 1'b1; m1_addr = 30'h3; m1_wdata = 64'h0123_4567_89AB_CDEF;
    step_txn(3, rand64(), 0, 0);

    // Timeout: memory never ready.
    pend0 = 1'b1; m0_addr = 30'h55;
    step_txn(100, rand64(), 0, 0);

    // Ready in the very last allowed cycle completes normally.
    pend0 = 1'b1; m0_addr = 30'h56;
    step_txn(TO - 1, 64'hCAFE_F00D_1234_5678, 0, 0);

    // Tie won by M0 moves the pointer; then reset mid-access restores it.
    pend0 = 1'b1; m0_addr = 30'h60;
    pend1 = 1'b1; m1_wen = 1'b0; m1_addr = 30'h61;
    step_txn(0, rand64(), 0, 0);
    @(negedge clk);
    chk("rm_idle_cen", mem_cen, 0);
    m0_req = 1'b0; m1_req = 1'b1;
    @(negedge clk);
    chk("rm_acc1_cen", mem_cen, 1);
    chk("rm_acc1_addr", mem_addr, 30'h61);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rm_acc2_cen", mem_cen, 1);
    rst = 1'b1; m1_req = 1'b0;
    @(negedge clk);
    chk("rm_after_cen", mem_cen, 0);
    chk("rm_after_m0_ack", m0_ack, 0);
    chk("rm_after_m1_ack", m1_ack, 0);
    rst = 1'b0;
    exp_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rm_noack_m0", m0_ack, 0);
      chk("rm_noack_m1", m1_ack, 0);
      chk("rm_noack_cen", mem_cen, 0);
    end
    pend0 = 1'b1; m0_addr = 30'h70;
    step_txn(0, rand64(), 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      step_txn(int'($urandom_range(0, TO + 1)), rand64(), ($urandom_range(0, 3) == 0), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
